intdiv_mulrec: RTL and testbench

- Sequential signed reconstructor: computes x = z*y + r from a quotient z, a divisor y and a remainder r.
- It is the inverse-direction companion of the array divider and serves as its on-line checker: feed it the divider's outputs and compare against the original dividend.
- Uses iterative radix-2 Booth recoding, one recoded quotient bit per clock, with a single start/busy/done handshake.

---
 rtl/intdiv_mulrec.sv | 143 ++++++++++++++
 tb/tb_intdiv_mulrec.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/intdiv_mulrec.sv
// intdiv_mulrec: sequential signed reconstructor x = z*y + r.
// Radix-2 Booth recoding of the quotient z, one recoded bit per clock,
// over a 2N-bit modular accumulator seeded with the sign-extended remainder.
// Flags overflow when the exact result does not fit N signed bits, and
// flags err when the result disagrees with the expected dividend xchk.
module intdiv_mulrec #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] z,
   input  logic [N-1:0] y,
   input  logic [N-1:0] r,
   input  logic [N-1:0] xchk,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] x,
   output logic         ovf,
   output logic         err
);

   localparam int KW = $clog2(N);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]     state_reg, state_next;
   logic [N-1:0]   z_reg, z_next;
   logic [N-1:0]   y_reg, y_next;
   logic [N-1:0]   xchk_reg, xchk_next;
   logic [2*N-1:0] acc_reg, acc_next;
   logic           zp_reg, zp_next;
   logic [KW-1:0]  k_reg, k_next;
   logic [N-1:0]   x_reg, x_next;
   logic           ovf_reg, ovf_next;
   logic           err_reg, err_next;

   logic [2*N-1:0] ys_shifted;
   logic [2*N-1:0] acc_step;
   logic           zk;
   logic [N-1:0]   sign_diff;
   logic           step_ovf;

   // Booth step datapath: shifted multiplicand and the recoded add/sub/hold
   always_comb begin
      ys_shifted = {{N{y_reg[N-1]}}, y_reg} << k_reg;
      zk         = z_reg[k_reg];
      acc_step   = acc_reg;
      case ({zk, zp_reg})
         2'b01:   acc_step = acc_reg + ys_shifted;
         2'b10:   acc_step = acc_reg - ys_shifted;
         default: acc_step = acc_reg;
      endcase
   end

   // The result fits N signed bits only if bits 2N-1 .. N-1 all equal the
   // sign; any neighbouring pair that differs marks an overflow.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_sign_diff
         assign sign_diff[gi] = acc_step[N + gi] ^ acc_step[N - 1 + gi];
      end
   endgenerate

   assign step_ovf = |sign_diff;

   // Next-state logic for the IDLE/RUN/DONE sequencer and its datapath
   always_comb begin
      state_next = state_reg;
      z_next     = z_reg;
      y_next     = y_reg;
      xchk_next  = xchk_reg;
      acc_next   = acc_reg;
      zp_next    = zp_reg;
      k_next     = k_reg;
      x_next     = x_reg;
      ovf_next   = ovf_reg;
      err_next   = err_reg;
      case (state_reg)
         S_RUN: begin
            acc_next = acc_step;
            zp_next  = zk;
            k_next   = k_reg + KW'(1);
            if (k_reg == KW'(N - 1)) begin
               // Final step: publish results computed from the last update
               state_next = S_DONE;
               x_next     = acc_step[N-1:0];
               ovf_next   = step_ovf;
               err_next   = step_ovf | (acc_step[N-1:0] != xchk_reg);
            end
         end
         default: begin
            // IDLE and DONE both accept a new operation
            if (start) begin
               state_next = S_RUN;
               z_next     = z;
               y_next     = y;
               xchk_next  = xchk;
               acc_next   = {{N{r[N-1]}}, r};
               zp_next    = 1'b0;
               k_next     = '0;
            end else if (state_reg == S_DONE) begin
               state_next = S_IDLE;
            end
         end
      endcase
   end

   // State registers with synchronous reset; a reset mid-run aborts the operation
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
         z_reg     <= '0;
         y_reg     <= '0;
         xchk_reg  <= '0;
         acc_reg   <= '0;
         zp_reg    <= 1'b0;
         k_reg     <= '0;
         x_reg     <= '0;
         ovf_reg   <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         z_reg     <= z_next;
         y_reg     <= y_next;
         xchk_reg  <= xchk_next;
         acc_reg   <= acc_next;
         zp_reg    <= zp_next;
         k_reg     <= k_next;
         x_reg     <= x_next;
         ovf_reg   <= ovf_next;
         err_reg   <= err_next;
      end
   end

   assign busy = (state_reg == S_RUN);
   assign done = (state_reg == S_DONE);
   assign x    = x_reg;
   assign ovf  = ovf_reg;
   assign err  = err_reg;

endmodule

// File: tb/tb_intdiv_mulrec.sv
// tb_intdiv_mulrec: directed table plus corner sequences and a random
// sweep checked against a 64-bit multiply-add reference.
module tb_intdiv_mulrec;

   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [N-1:0] z = '0, y = '0, r = '0, xchk = '0;
   logic         busy, done, ovf, err;
   logic [N-1:0] x;

   int tests = 0;
   int fails = 0;

   intdiv_mulrec #(.N(N)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .z    (z),
      .y    (y),
      .r    (r),
      .xchk (xchk),
      .busy (busy),
      .done (done),
      .x    (x),
      .ovf  (ovf),
      .err  (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] z;
      logic [N-1:0] y;
      logic [N-1:0] r;
      logic [N-1:0] xchk;
      logic [N-1:0] ex;
      logic         eovf;
      logic         eerr;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Issue one operation from a negedge, wait for done (bounded), sample at negedge.
   task automatic do_op(input logic [N-1:0] zv, yv, rv, cv,
                        output logic [N-1:0] xo, output logic ovfo, erro,
                        output int lat, output int busy_cnt);
      @(negedge clk);
      z = zv; y = yv; r = rv; xchk = cv; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      busy_cnt = 0;
      while (!done && lat < 100) begin
         if (busy) busy_cnt++;
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      xo = x; ovfo = ovf; erro = err;
   endtask

   function automatic void model(input logic [N-1:0] zv, yv, rv, cv,
                                 output logic [N-1:0] ex, output logic eovf, eerr);
      longint p;
      p    = longint'($signed(zv)) * longint'($signed(yv)) + longint'($signed(rv));
      ex   = p[N-1:0];
      eovf = (p != longint'($signed(p[N-1:0])));
      eerr = eovf | (p[N-1:0] != cv);
   endfunction

   initial begin
      logic [N-1:0] gx;
      logic         govf, gerr, seen;
      int           lat, bc;
      logic [N-1:0] rz, ry, rr, rc, ex;
      logic         eovf, eerr;

      vecs[0] = '{32'd4, 32'd7, 32'd2, 32'd30, 32'd30, 1'b0, 1'b0};
      vecs[1] = '{-32'sd10, 32'd11, -32'sd10, -32'sd120, 32'hFFFF_FF88, 1'b0, 1'b0};
      vecs[2] = '{-32'sd10, 32'd11, -32'sd9, -32'sd120, -32'sd119, 1'b0, 1'b1};
      vecs[3] = '{32'h4000_0000, 32'd2, 32'd0, 32'd0, 32'h8000_0000, 1'b1, 1'b1};
      vecs[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1};
      vecs[5] = '{32'd5, 32'd0, 32'd7, 32'd7, 32'd7, 1'b0, 1'b0};
      vecs[6] = '{32'd0, 32'd12345, -32'sd3, -32'sd3, 32'hFFFF_FFFD, 1'b0, 1'b0};
      vecs[7] = '{32'h8000_0000, 32'd1, 32'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0};
      vecs[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd1, 1'b0, 1'b0};
      vecs[9] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0, 32'd0, 32'd1, 1'b1, 1'b1};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset_outs", {59'd0, busy, done, ovf, err, 1'b0}, 64'd0);
      chk("reset_x", {32'd0, x}, 64'd0);

      // Directed table
      for (int i = 0; i < 10; i++) begin
         do_op(vecs[i].z, vecs[i].y, vecs[i].r, vecs[i].xchk, gx, govf, gerr, lat, bc);
         $display("[TB] vec %0d z=%h y=%h r=%h -> x=%h ovf=%b err=%b lat=%0d",
                  i, vecs[i].z, vecs[i].y, vecs[i].r, gx, govf, gerr, lat);
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(N));
         chk($sformatf("vec%0d_busycnt", i), 64'(bc), 64'(N));
         chk($sformatf("vec%0d_x", i), {32'd0, gx}, {32'd0, vecs[i].ex});
         chk($sformatf("vec%0d_flags", i), {62'd0, govf, gerr}, {62'd0, vecs[i].eovf, vecs[i].eerr});
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("vec%0d_pulse_hold", i), {29'd0, done, busy, gerr, x},
             {29'd0, 1'b0, 1'b0, vecs[i].eerr, vecs[i].ex});
      end

      // Restart in the done cycle
      do_op(32'd5, 32'd0, 32'd7, 32'd7, gx, govf, gerr, lat, bc);
      chk("b2b_first_x", {32'd0, gx}, 64'd7);
      z = 32'hFFFF_FFFF; y = 32'hFFFF_FFFF; r = 32'd0; xchk = 32'd1; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_accept", {62'd0, busy, done}, 64'd2);
      lat = 0;
      while (!done && lat < 100) begin
         @(posedge clk); lat++; @(negedge clk);
      end
      $display("[TB] back-to-back x=%h ovf=%b err=%b lat=%0d", x, ovf, err, lat);
      chk("b2b_latency", 64'(lat), 64'(N));
      chk("b2b_x", {30'd0, ovf, err, x}, 64'd1);
      @(posedge clk);
      @(negedge clk);

      // Start while busy is ignored
      z = 32'd3; y = 32'd5; r = 32'd1; xchk = 32'd16; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 100) begin
         if (lat == 5) begin
            z = 32'd100; y = 32'd100; r = 32'd100; xchk = 32'd0; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); lat++; @(negedge clk);
      end
      start = 1'b0;
      $display("[TB] midrun-start x=%h ovf=%b err=%b lat=%0d", x, ovf, err, lat);
      chk("midrun_latency", 64'(lat), 64'(N));
      chk("midrun_x", {30'd0, ovf, err, x}, 64'd16);

      // Reset in the middle of a run aborts it
      @(posedge clk);
      @(negedge clk);
      z = 32'd7; y = 32'd9; r = 32'd1; xchk = 32'd64; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      $display("[TB] reset-abort busy=%b done=%b x=%h ovf=%b err=%b", busy, done, x, ovf, err);
      chk("abort_outs", {28'd0, busy, done, ovf, err, x}, 64'd0);
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (done || busy) seen = 1'b1;
      end
      chk("abort_no_done", {63'd0, seen}, 64'd0);

      // Random sweep against the reference model
      for (int i = 0; i < 1000; i++) begin
         rz = $urandom;
         ry = $urandom;
         rr = $urandom;
         case (i % 4)
            0: rz = rz >>> 20;
            1: ry = $signed(ry) >>> 18;
            default: ;
         endcase
         model(rz, ry, rr, 32'd0, ex, eovf, eerr);
         rc = ($urandom_range(0, 1) == 1) ? ex : $urandom;
         model(rz, ry, rr, rc, ex, eovf, eerr);
         do_op(rz, ry, rr, rc, gx, govf, gerr, lat, bc);
         $display("[TB] rnd %0d z=%h y=%h r=%h c=%h -> x=%h ovf=%b err=%b", i, rz, ry, rr, rc, gx, govf, gerr);
         chk($sformatf("rnd%0d", i), {29'd0, govf, gerr, lat == N, gx},
             {29'd0, eovf, eerr, 1'b1, ex});
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
